// File: rtl/dac_seq_ctrl.sv
// Sample-rate-paced DAC feeder: FIFO of 10-bit codes popped once per sample period,
// driven onto the DAC input register, with a settle counter reporting a valid output.
module dac_seq_ctrl #(
   parameter int unsigned CLKDIV_WIDTH = 8,
   parameter int unsigned FIFO_AW      = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [CLKDIV_WIDTH-1:0] clkdiv,
   input  logic [3:0]              swidth,
   input  logic                    wr,
   input  logic [9:0]              wdata,
   input  logic [FIFO_AW:0]        fifo_threshold,
   input  logic                    clr_flags,
   output logic [9:0]              dac_data,
   output logic                    dac_load,
   output logic                    dac_valid,
   output logic                    fifo_full,
   output logic                    fifo_empty,
   output logic [FIFO_AW:0]        fifo_level,
   output logic                    fifo_below,
   output logic                    underrun,
   output logic                    tick_miss
);

   localparam int unsigned Depth = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] LevelFull = (FIFO_AW + 1)'(Depth);

   typedef enum logic {StIdle, StSettle} state_e;

   state_e                  state_q, state_d;
   logic [CLKDIV_WIDTH-1:0] ctr_q, ctr_d;
   logic [3:0]              scnt_q, scnt_d;
   logic [9:0]              dac_data_q, dac_data_d;
   logic                    dac_load_q, dac_load_d;
   logic                    dac_valid_q, dac_valid_d;
   logic                    underrun_q, underrun_d;
   logic                    tick_miss_q, tick_miss_d;
   logic [FIFO_AW-1:0]      wptr_q, wptr_d;
   logic [FIFO_AW-1:0]      rptr_q, rptr_d;
   logic [FIFO_AW:0]        level_q, level_d;
   logic [9:0]              mem_q [Depth];

   logic tick, push, pop, set_underrun, set_miss;

   assign tick = en & (ctr_q == clkdiv);

   always_comb begin
      state_d      = state_q;
      ctr_d        = ctr_q;
      scnt_d       = scnt_q;
      dac_data_d   = dac_data_q;
      dac_load_d   = 1'b0;
      dac_valid_d  = dac_valid_q;
      pop          = 1'b0;
      set_underrun = 1'b0;
      set_miss     = 1'b0;

      if (!en) begin
         ctr_d   = '0;
         state_d = StIdle;
         scnt_d  = '0;
      end else begin
         ctr_d = tick ? '0 : ctr_q + 1'b1;
         unique case (state_q)
            StIdle: begin
               // Empty check uses registered level, so a same-cycle push cannot be popped.
               if (tick) begin
                  if (fifo_empty) begin
                     set_underrun = 1'b1;
                  end else begin
                     pop         = 1'b1;
                     dac_data_d  = mem_q[rptr_q];
                     dac_load_d  = 1'b1;
                     dac_valid_d = 1'b0;
                     scnt_d      = '0;
                     state_d     = StSettle;
                  end
               end
            end
            StSettle: begin
               if (tick) set_miss = 1'b1;
               if (scnt_q == swidth) begin
                  dac_valid_d = 1'b1;
                  state_d     = StIdle;
               end else begin
                  scnt_d = scnt_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      push   = wr & ~fifo_full;
      wptr_d = push ? wptr_q + 1'b1 : wptr_q;
      rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      // Set wins over a coincident clear.
      underrun_d  = (underrun_q & ~clr_flags) | set_underrun;
      tick_miss_d = (tick_miss_q & ~clr_flags) | set_miss;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ctr_q       <= '0;
         scnt_q      <= '0;
         dac_data_q  <= '0;
         dac_load_q  <= 1'b0;
         dac_valid_q <= 1'b0;
         underrun_q  <= 1'b0;
         tick_miss_q <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         level_q     <= '0;
      end else begin
         state_q     <= state_d;
         ctr_q       <= ctr_d;
         scnt_q      <= scnt_d;
         dac_data_q  <= dac_data_d;
         dac_load_q  <= dac_load_d;
         dac_valid_q <= dac_valid_d;
         underrun_q  <= underrun_d;
         tick_miss_q <= tick_miss_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         level_q     <= level_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= wdata;
   end

   assign dac_data   = dac_data_q;
   assign dac_load   = dac_load_q;
   assign dac_valid  = dac_valid_q;
   assign fifo_level = level_q;
   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == LevelFull);
   assign fifo_below = (level_q < fifo_threshold);
   assign underrun   = underrun_q;
   assign tick_miss  = tick_miss_q;

endmodule
